// File: rtl/instr_encoder_if.sv
`default_nettype none
// instr_encoder_if: host request channel plus instruction-memory write port.
// The host loader drives the master side; instr_encoder drives the slave side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_op;
  logic [3:0]        req_operand;
  logic              req_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_wdata;

  modport master (
    output req_valid, req_op, req_operand, req_last,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_operand, req_last,
    output req_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// instr_encoder: legalises and encodes host requests into {op,operand} words, buffers them
// and streams them to instruction memory. Define ALIGN_PAD_EN to NOP-pad to a 4-word boundary (ADDR_W >= 2).
module instr_encoder #(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              start_i,
  instr_encoder_if.slave         bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_illegal_o,
  output logic [ADDR_W-1:0]      word_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_DONE} state_t;

  state_t            state_q;
  logic [8:0]        fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic              last_seen_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q, addr_d, wcount_q, wcount_d;

  logic       illegal, full, empty, push, pop, pad_we, write, drain, need_pad, start_ok;
  logic [8:0] enc_word;

  // Unassigned opcodes are 10010..10101; they collapse to a bare NOP.
  assign illegal  = ((bus.req_op[4:2] == 3'b100) &&  bus.req_op[1]) ||
                    ((bus.req_op[4:2] == 3'b101) && !bus.req_op[1]);
  assign enc_word = illegal ? 9'h000 : {bus.req_op, bus.req_operand};

  assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign bus.req_ready = (state_q == S_LOAD) && !full && !last_seen_q;
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state_q == S_LOAD) && !empty;
  assign drain         = (state_q == S_LOAD) && last_seen_q && empty;

`ifdef ALIGN_PAD_EN
  assign pad_we   = (state_q == S_PAD);
  assign need_pad = (addr_q[1:0] != 2'b00);
`else
  assign pad_we   = 1'b0;
  assign need_pad = 1'b0;
`endif

  assign write         = pop || pad_we;
  assign bus.mem_we    = write;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = pop ? fifo_q[rd_ptr_q] : 9'h000;

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_illegal_o = err_q;
  assign word_count_o  = wcount_q;

  always_comb begin
    addr_d   = addr_q;
    wcount_d = wcount_q;
    count_d  = count_q;
    if (start_ok) begin
      addr_d   = BASE_ADDR;
      wcount_d = '0;
    end else if (write) begin
      addr_d   = addr_q + ADDR_W'(1);
      wcount_d = (wcount_q == '1) ? wcount_q : wcount_q + ADDR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= BASE_ADDR;
      wcount_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      wcount_q <= wcount_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (push && bus.req_last) last_seen_q <= 1'b1;
          if (push && illegal)      err_q       <= 1'b1;
          if (drain) begin
            if (need_pad) begin
              state_q <= S_PAD;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
`ifdef ALIGN_PAD_EN
        S_PAD: begin
          if (addr_d[1:0] == 2'b00) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential program loader that encodes operation requests into 9-bit machine words and writes them into instruction memory.
- Word format: [8:4] = 5-bit opcode, [3:0] = operand or immediate.
- Sits between the host/debug loader port and the instruction memory write port; it produces the words that the core's control decoder later consumes.
- Legalises opcodes, buffers requests in a small FIFO, and sequences memory writes with an address counter.

Parameters:
- FIFO_DEPTH, 4, request buffer entries; power of two, at least 2.
- ADDR_W, 8, instruction memory address width.
- BASE_ADDR, 0, first write address after start.

Ports:
- Clk  in  1  clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  5  opcode.
- req_operand  in  4  register index or 4-bit immediate.
- req_last  in  1  marks the final request of the session.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  9  encoded word.
- busy  out  1  session active (state LOAD or PAD).
- done  out  1  high in DONE until the next start.
- err_illegal  out  1  sticky flag: an illegal opcode was seen this session.
- word_count  out  ADDR_W  words written this session.

Behaviour:
- Reset values: req_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err_illegal=0, word_count=0, FIFO empty, state IDLE.
- Reset asserted mid-session aborts immediately: all outputs return to their reset values and no further write is issued.
- Legal opcode set: 00000–00111, 01000–01111, 10000, 10001, 10110, 10111, 11000–11111.
  - Illegal opcodes are encoded as NOP (9'h000) and set err_illegal; the operand is dropped.
  - Opcodes 00000 (NOP), 11111 (SWAP) and 00010 (B) are encoded with the operand unchanged.
- States:
  - IDLE: req_ready=0. start -> LOAD; clears word_count, err_illegal and done; mem_addr=BASE_ADDR.
  - LOAD: req_ready = !fifo_full && !last_seen.
    - Each accepted request is encoded and pushed to the FIFO in the same cycle. Encoding is combinational; words enter the FIFO already encoded.
    - Whenever the FIFO is non-empty, pop one word per cycle: mem_we=1, mem_wdata=word, mem_addr=current address. Address and word_count increment the cycle after the write.
    - Latency: an accepted request appears on mem_we/mem_wdata at the earliest on the next cycle (registered FIFO output).
    - Push and pop in the same cycle are both allowed; occupancy stays unchanged.
    - Once req_last is accepted, last_seen=1. When the FIFO drains: -> PAD if ALIGN_PAD_EN, else -> DONE.
  - PAD: see Optional Feature.
  - DONE: done=1, busy=0, mem_we=0. start -> LOAD (new session).
- start while busy is ignored.
- mem_addr wraps modulo 2^ADDR_W. word_count saturates at all-ones.
- req_valid with no session active is never accepted (req_ready=0).

Optional Feature:
- Macro: ALIGN_PAD_EN.
- Defined: after the FIFO drains, the PAD state writes NOP words (mem_wdata=0, mem_we=1) one per cycle until mem_addr[1:0]==0, then -> DONE.
  - PAD writes count toward word_count.
  - If mem_addr is already aligned, PAD lasts 0 cycles and the block goes straight to DONE.
- Undefined: the PAD state does not exist; LOAD drains directly to DONE.

Test Plan:
- Reset=0 mid-LOAD with 2 words queued -> next edge: mem_we=0, busy=0, mem_addr=0, FIFO empty; a later start begins cleanly at address 0.
- start, then 3 requests {01000/0011, 11001/0101, 00011/1111 last}, one per cycle, BASE_ADDR=0 -> writes 0x083@0, 0x195@1, 0x03F@2; word_count=3; done=1; err_illegal=0.
- Request op=10010, operand=7 -> write 0x000; err_illegal=1 sticky until the next start.
- Host holds req_valid=1 for 6 requests with FIFO_DEPTH=4 while memory drains one per cycle -> no request lost or duplicated, in-order addresses 0–5, req_ready never high while the FIFO is full.
- ALIGN_PAD_EN defined, 5 words written -> NOPs at addresses 5, 6, 7, then done; word_count=8. Undefined -> done after address 4; word_count=5.
- ADDR_W=3, BASE_ADDR=6, 4 words -> addresses 6, 7, 0, 1 (wrap); start pulsed while busy -> ignored.
